// File: rtl/vx_launch_ctrl.sv
// rtl/vx_launch_ctrl.sv - Vortex kernel-launch sequencer: DCR programming, GPU reset release, busy watch
module vx_launch_ctrl #(
  parameter int                    DCR_ADDR_W   = 12,
  parameter logic [DCR_ADDR_W-1:0] DCR_STARTUP0 = DCR_ADDR_W'(1),
  parameter logic [DCR_ADDR_W-1:0] DCR_STARTUP1 = DCR_ADDR_W'(2),
  parameter logic [DCR_ADDR_W-1:0] DCR_ARG0     = DCR_ADDR_W'(3),
  parameter logic [DCR_ADDR_W-1:0] DCR_ARG1     = DCR_ADDR_W'(4),
  parameter int                    DCR_GAP      = 1,
  parameter int                    RESET_HOLD   = 9,
  parameter int                    RISE_MAX     = 1024,
  parameter int                    RUN_MAX      = 12216
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           startup_addr0,
  input  logic [31:0]           startup_addr1,
  input  logic [31:0]           kernel_arg0,
  input  logic [31:0]           kernel_arg1,
  output logic                  idle,
  output logic                  dcr_wr_valid,
  output logic [DCR_ADDR_W-1:0] dcr_wr_addr,
  output logic [31:0]           dcr_wr_data,
  output logic                  vx_reset,
  input  logic                  busy,
  output logic                  done,
  output logic [1:0]            status,
  output logic [31:0]           run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_GAP,
    S_HOLD,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_NO_RISE = 2'd1;
  localparam logic [1:0] ST_RUN_TO  = 2'd2;
  localparam logic [1:0] ST_ABORT   = 2'd3;

  state_t      state;
  logic [1:0]  idx;
  logic [1:0]  nxt_idx;
  logic [31:0] cnt;
  logic [31:0] op [4];
  logic        active;

  assign nxt_idx = idx + 2'd1;
  // States in which an abort request cancels the launch
  assign active  = (state == S_WR) || (state == S_GAP) || (state == S_HOLD) ||
                   (state == S_WAIT_HI) || (state == S_WAIT_LO);

  function automatic logic [DCR_ADDR_W-1:0] addr_of(input logic [1:0] i);
    logic [DCR_ADDR_W-1:0] a;
    case (i)
      2'd0: a = DCR_STARTUP0;
      2'd1: a = DCR_STARTUP1;
      2'd2: a = DCR_ARG0;
      2'd3: a = DCR_ARG1;
    endcase
    return a;
  endfunction

  // Launch sequencer: state and all outputs advance together, one step per clock
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= 2'd0;
      cnt          <= '0;
      for (int i = 0; i < 4; i++) op[i] <= '0;
      idle         <= 1'b1;
      dcr_wr_valid <= 1'b0;
      dcr_wr_addr  <= '0;
      dcr_wr_data  <= '0;
      vx_reset     <= 1'b1;
      done         <= 1'b0;
      status       <= ST_OK;
      run_cycles   <= '0;
    end else begin
      // strobe-type outputs default low; address/data are zeroed whenever no write is issued
      dcr_wr_valid <= 1'b0;
      dcr_wr_addr  <= '0;
      dcr_wr_data  <= '0;
      done         <= 1'b0;
      if (abort && active) begin
        state    <= S_DONE;
        status   <= ST_ABORT;
        done     <= 1'b1;
        vx_reset <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              op[0]        <= startup_addr0;
              op[1]        <= startup_addr1;
              op[2]        <= kernel_arg0;
              op[3]        <= kernel_arg1;
              run_cycles   <= '0;
              status       <= ST_OK;
              idx          <= 2'd0;
              idle         <= 1'b0;
              state        <= S_WR;
              dcr_wr_valid <= 1'b1;
              dcr_wr_addr  <= DCR_STARTUP0;
              dcr_wr_data  <= startup_addr0;
            end
          end
          S_WR: begin
            cnt <= '0;
            if (idx == 2'd3) begin
              state <= S_HOLD;
            end else if (DCR_GAP == 0) begin
              idx          <= nxt_idx;
              dcr_wr_valid <= 1'b1;
              dcr_wr_addr  <= addr_of(nxt_idx);
              dcr_wr_data  <= op[nxt_idx];
            end else begin
              state <= S_GAP;
            end
          end
          S_GAP: begin
            if (cnt == 32'(DCR_GAP - 1)) begin
              state        <= S_WR;
              idx          <= nxt_idx;
              dcr_wr_valid <= 1'b1;
              dcr_wr_addr  <= addr_of(nxt_idx);
              dcr_wr_data  <= op[nxt_idx];
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          S_HOLD: begin
            if (cnt == 32'(RESET_HOLD - 1)) begin
              state    <= S_WAIT_HI;
              vx_reset <= 1'b0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          S_WAIT_HI: begin
            // the cycle in which busy is first seen already counts as a busy cycle
            if (busy) begin
              run_cycles <= 32'd1;
              if (RUN_MAX <= 1) begin
                state    <= S_DONE;
                status   <= ST_RUN_TO;
                done     <= 1'b1;
                vx_reset <= 1'b1;
              end else begin
                state <= S_WAIT_LO;
              end
            end else if (cnt == 32'(RISE_MAX)) begin
              state    <= S_DONE;
              status   <= ST_NO_RISE;
              done     <= 1'b1;
              vx_reset <= 1'b1;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          S_WAIT_LO: begin
            if (!busy) begin
              state    <= S_DONE;
              status   <= ST_OK;
              done     <= 1'b1;
              vx_reset <= 1'b1;
            end else begin
              run_cycles <= run_cycles + 32'd1;
              if (run_cycles + 32'd1 == 32'(RUN_MAX)) begin
                state    <= S_DONE;
                status   <= ST_RUN_TO;
                done     <= 1'b1;
                vx_reset <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            idle  <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            idle  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
